// File: rtl/mem_pkg.sv
// Shared defaults and read-arbiter state encoding for the memory stream controller.
package mem_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned ADDR_WIDTH_DEF = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } grantState_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin read arbiter; the state register doubles as the
// registered read-port select.
module rr_arbiter2
    import mem_pkg::*;
(
    input  logic        Clock,
    input  logic        Reset,
    input  logic        reqA,
    input  logic        reqB,
    input  logic        avail,
    output logic        issueA_c,
    output logic        issueB_c,
    output grantState_t state
);

    grantState_t nextState;
    logic        lastGrantB;

    // Ties go to whichever requester was not served last.
    always_comb begin
        nextState = IDLE;
        if (avail) begin
            if (reqA && reqB) begin
                nextState = lastGrantB ? GRANT_A : GRANT_B;
            end else if (reqA) begin
                nextState = GRANT_A;
            end else if (reqB) begin
                nextState = GRANT_B;
            end
        end
    end

    assign issueA_c = (nextState == GRANT_A);
    assign issueB_c = (nextState == GRANT_B);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            lastGrantB <= 1'b1;
        end else begin
            state <= nextState;
            if (nextState == GRANT_A) begin
                lastGrantB <= 1'b0;
            end else if (nextState == GRANT_B) begin
                lastGrantB <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_stream_ctrl.sv
// Circular-FIFO controller for an external memory: streams upstream bytes into
// the write port and serves two consumers from the read port.
module mem_stream_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iValid,
    input  logic [DATA_WIDTH-1:0] iData,
    output logic                  oReady,
    input  logic                  iReqa,
    input  logic                  iReqb,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oAddress,
    output logic [DATA_WIDTH-1:0] oDataIn,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    output logic                  oReadtoa,
    output logic                  oReadtob,
    output logic                  oDataValida,
    output logic                  oDataValidb,
    output logic [ADDR_WIDTH:0]   oCount,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oOverflow
);

    localparam int unsigned CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH = CW'(2 ** ADDR_WIDTH);

    logic [ADDR_WIDTH-1:0] wrPtr;
    logic [ADDR_WIDTH-1:0] rdPtr;
    logic [CW-1:0]         count;
    logic [CW-1:0]         committed;
    logic                  pendingWrite;
    logic                  accept;
    logic                  issue;
    logic                  issueA_c;
    logic                  issueB_c;
    grantState_t           grantState;

    // The byte in flight on the write port is counted but not yet readable.
    assign pendingWrite = oWriteEnable;
    assign committed    = count - CW'(pendingWrite);

    assign oCount = count;
    assign oFull  = (count == DEPTH);
    assign oEmpty = (committed == '0);
    assign oReady = !oFull;
    assign accept = iValid && oReady;
    assign issue  = issueA_c || issueB_c;

    rr_arbiter2 uArb (
        .Clock    (Clock),
        .Reset    (Reset),
        .reqA     (iReqa),
        .reqB     (iReqb),
        .avail    (!oEmpty),
        .issueA_c (issueA_c),
        .issueB_c (issueB_c),
        .state    (grantState)
    );

    assign oReadtoa = (grantState == GRANT_A);
    assign oReadtob = (grantState == GRANT_B);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            wrPtr        <= '0;
            rdPtr        <= '0;
            count        <= '0;
            oWriteEnable <= 1'b0;
            oAddress     <= '0;
            oDataIn      <= '0;
            oReadAddress <= '0;
            oDataValida  <= 1'b0;
            oDataValidb  <= 1'b0;
            oOverflow    <= 1'b0;
        end else begin
            oWriteEnable <= accept;
            if (accept) begin
                oAddress <= wrPtr;
                oDataIn  <= iData;
                wrPtr    <= wrPtr + ADDR_WIDTH'(1);
            end

            if (issue) begin
                oReadAddress <= rdPtr;
                rdPtr        <= rdPtr + ADDR_WIDTH'(1);
            end

            // Memory output is valid the cycle after the select strobe.
            oDataValida <= oReadtoa;
            oDataValidb <= oReadtob;

            case ({accept, issue})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            if (iValid && oFull) begin
                oOverflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_stream_ctrl.sv
// Directed bench for mem_stream_ctrl with a behavioural dual-output memory.
module tb_mem_stream_ctrl;
    import mem_pkg::*;

    localparam int unsigned DW = DATA_WIDTH_DEF;
    localparam int unsigned AW = ADDR_WIDTH_DEF;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iValid;
    logic [DW-1:0] iData;
    logic          oReady;
    logic          iReqa;
    logic          iReqb;
    logic          oWriteEnable;
    logic [AW-1:0] oAddress;
    logic [DW-1:0] oDataIn;
    logic [AW-1:0] oReadAddress;
    logic          oReadtoa;
    logic          oReadtob;
    logic          oDataValida;
    logic          oDataValidb;
    logic [AW:0]   oCount;
    logic          oFull;
    logic          oEmpty;
    logic          oOverflow;
    logic [DW-1:0] oDataOuta;
    logic [DW-1:0] oDataOutb;
    logic [DW-1:0] mem [0:(2**AW)-1];

    int total = 0;
    int bad   = 0;

    mem_stream_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iValid       (iValid),
        .iData        (iData),
        .oReady       (oReady),
        .iReqa        (iReqa),
        .iReqb        (iReqb),
        .oWriteEnable (oWriteEnable),
        .oAddress     (oAddress),
        .oDataIn      (oDataIn),
        .oReadAddress (oReadAddress),
        .oReadtoa     (oReadtoa),
        .oReadtob     (oReadtob),
        .oDataValida  (oDataValida),
        .oDataValidb  (oDataValidb),
        .oCount       (oCount),
        .oFull        (oFull),
        .oEmpty       (oEmpty),
        .oOverflow    (oOverflow)
    );

    always #5 Clock = ~Clock;

    // Synchronous memory: one write port, registered read data per consumer.
    always @(posedge Clock) begin
        if (oWriteEnable) mem[oAddress] <= oDataIn;
        if (oReadtoa) oDataOuta <= mem[oReadAddress];
        if (oReadtob) oDataOutb <= mem[oReadAddress];
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic doReset();
        Reset  = 1'b1;
        iValid = 1'b0;
        iReqa  = 1'b0;
        iReqb  = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1; iValid = 1'b0; iData = '0; iReqa = 1'b0; iReqb = 1'b0;
        tick(); tick();
        chk("rst empty", 32'(oEmpty), 32'd1);
        chk("rst full", 32'(oFull), 32'd0);
        chk("rst ready", 32'(oReady), 32'd1);
        chk("rst count", 32'(oCount), 32'd0);
        chk("rst we", 32'(oWriteEnable), 32'd0);
        chk("rst rda", 32'(oReadtoa), 32'd0);
        chk("rst ovf", 32'(oOverflow), 32'd0);
        Reset = 1'b0;

        // Three back-to-back bytes, consumer A held.
        iValid = 1'b1; iData = 8'h11; iReqa = 1'b1;
        tick();
        chk("t1 we c1", 32'(oWriteEnable), 32'd1);
        chk("t1 addr c1", 32'(oAddress), 32'd0);
        chk("t1 din c1", 32'(oDataIn), 32'h11);
        iData = 8'h22;
        tick();
        chk("t1 addr c2", 32'(oAddress), 32'd1);
        chk("t1 din c2", 32'(oDataIn), 32'h22);
        chk("t1 rda c2", 32'(oReadtoa), 32'd0);
        iData = 8'h33;
        tick();
        chk("t1 addr c3", 32'(oAddress), 32'd2);
        chk("t1 din c3", 32'(oDataIn), 32'h33);
        chk("t1 rda c3", 32'(oReadtoa), 32'd1);
        chk("t1 raddr c3", 32'(oReadAddress), 32'd0);
        iValid = 1'b0;
        tick();
        chk("t1 we c4", 32'(oWriteEnable), 32'd0);
        chk("t1 raddr c4", 32'(oReadAddress), 32'd1);
        chk("t1 dva c4", 32'(oDataValida), 32'd1);
        chk("t1 douta c4", 32'(oDataOuta), 32'h11);
        tick();
        chk("t1 raddr c5", 32'(oReadAddress), 32'd2);
        chk("t1 douta c5", 32'(oDataOuta), 32'h22);
        tick();
        chk("t1 rda c6", 32'(oReadtoa), 32'd0);
        chk("t1 dva c6", 32'(oDataValida), 32'd1);
        chk("t1 douta c6", 32'(oDataOuta), 32'h33);
        chk("t1 empty", 32'(oEmpty), 32'd1);
        chk("t1 count", 32'(oCount), 32'd0);
        iReqa = 1'b0;

        // Fill to full, then one more byte overflows.
        doReset();
        iValid = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            iData = 8'(i);
            tick();
        end
        chk("t2 full", 32'(oFull), 32'd1);
        chk("t2 ready", 32'(oReady), 32'd0);
        chk("t2 count", 32'(oCount), 32'd1024);
        chk("t2 last addr", 32'(oAddress), 32'd1023);
        tick();
        chk("t2 ovf", 32'(oOverflow), 32'd1);
        chk("t2 count ovf", 32'(oCount), 32'd1024);
        chk("t2 no we", 32'(oWriteEnable), 32'd0);
        iValid = 1'b0;
        tick();
        chk("t2 ovf sticky", 32'(oOverflow), 32'd1);
        chk("t2 full hold", 32'(oFull), 32'd1);

        // Four bytes, both consumers held: A,B,A,B.
        doReset();
        chk("t3 ovf cleared", 32'(oOverflow), 32'd0);
        iValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iData = 8'(8'hA0 + i);
            tick();
        end
        iValid = 1'b0; iReqa = 1'b1; iReqb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3 rda", 32'(oReadtoa), (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("t3 rdb", 32'(oReadtob), (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("t3 raddr", 32'(oReadAddress), 32'(k));
        end
        tick();
        chk("t3 rda end", 32'(oReadtoa), 32'd0);
        chk("t3 rdb end", 32'(oReadtob), 32'd0);
        chk("t3 empty", 32'(oEmpty), 32'd1);
        tick();
        chk("t3 rda idle", 32'(oReadtoa), 32'd0);
        chk("t3 rdb idle", 32'(oReadtob), 32'd0);
        iReqa = 1'b0; iReqb = 1'b0;

        // Move both pointers to 1022, then cross the wrap.
        doReset();
        iValid = 1'b1; iReqa = 1'b1;
        for (int i = 0; i < 1022; i++) begin
            iData = 8'(i);
            tick();
        end
        iValid = 1'b0;
        repeat (6) tick();
        chk("t4 drained", 32'(oEmpty), 32'd1);
        chk("t4 count0", 32'(oCount), 32'd0);
        iReqa = 1'b0; iReqb = 1'b1; iValid = 1'b1; iData = 8'hC0;
        tick();
        chk("t4 addr 1022", 32'(oAddress), 32'd1022);
        iData = 8'hC1;
        tick();
        chk("t4 addr 1023", 32'(oAddress), 32'd1023);
        iData = 8'hC2;
        tick();
        chk("t4 addr 0", 32'(oAddress), 32'd0);
        chk("t4 rdb c3", 32'(oReadtob), 32'd1);
        chk("t4 raddr 1022", 32'(oReadAddress), 32'd1022);
        iData = 8'hC3;
        tick();
        chk("t4 addr 1", 32'(oAddress), 32'd1);
        chk("t4 raddr 1023", 32'(oReadAddress), 32'd1023);
        chk("t4 doutb c0", 32'(oDataOutb), 32'hC0);
        iValid = 1'b0;
        tick();
        chk("t4 raddr 0", 32'(oReadAddress), 32'd0);
        chk("t4 doutb c1", 32'(oDataOutb), 32'hC1);
        tick();
        chk("t4 raddr 1", 32'(oReadAddress), 32'd1);
        chk("t4 doutb c2", 32'(oDataOutb), 32'hC2);
        tick();
        chk("t4 rdb end", 32'(oReadtob), 32'd0);
        chk("t4 doutb c3", 32'(oDataOutb), 32'hC3);
        chk("t4 count end", 32'(oCount), 32'd0);
        iReqb = 1'b0;

        // Simultaneous accept and read at count 5.
        doReset();
        iValid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            iData = 8'(8'h50 + i);
            tick();
        end
        iValid = 1'b0;
        tick();
        chk("t5 count5", 32'(oCount), 32'd5);
        iValid = 1'b1; iData = 8'h55; iReqa = 1'b1;
        tick();
        chk("t5 count same", 32'(oCount), 32'd5);
        chk("t5 we", 32'(oWriteEnable), 32'd1);
        chk("t5 rda", 32'(oReadtoa), 32'd1);
        iValid = 1'b0; iReqa = 1'b0;
        tick();
        chk("t5 count hold", 32'(oCount), 32'd5);

        // Reset mid-stream at count 7.
        iValid = 1'b1; iData = 8'h56;
        tick();
        iData = 8'h57;
        tick();
        iData = 8'h58; iReqa = 1'b1;
        tick();
        chk("t6 count7", 32'(oCount), 32'd7);
        chk("t6 rda pre", 32'(oReadtoa), 32'd1);
        Reset = 1'b1;
        #1;
        chk("t6 count", 32'(oCount), 32'd0);
        chk("t6 empty", 32'(oEmpty), 32'd1);
        chk("t6 ready", 32'(oReady), 32'd1);
        chk("t6 we", 32'(oWriteEnable), 32'd0);
        chk("t6 rda", 32'(oReadtoa), 32'd0);
        chk("t6 addr", 32'(oAddress), 32'd0);
        chk("t6 raddr", 32'(oReadAddress), 32'd0);
        chk("t6 din", 32'(oDataIn), 32'd0);
        tick();
        chk("t6 we held", 32'(oWriteEnable), 32'd0);
        Reset = 1'b0; iReqa = 1'b0; iData = 8'h5A;
        tick();
        chk("t6 we post", 32'(oWriteEnable), 32'd1);
        chk("t6 addr post", 32'(oAddress), 32'd0);
        chk("t6 din post", 32'(oDataIn), 32'h5A);
        chk("t6 count post", 32'(oCount), 32'd1);
        iValid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stream_ctrl.md
MEM_STREAM_CTRL -- requirements
Module: mem_stream_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 10, memory address width (depth 2**ADDR_WIDTH = 1024).
REQ-003 SHALL use one clock and an asynchronous, active-high reset: Clock  in  1  rising-edge clock.
REQ-004 SHALL have Reset  in  1  asynchronous active-high reset.
REQ-005 SHALL have iValid  in  1  upstream byte valid; iData  in  DATA_WIDTH  upstream byte.
REQ-006 SHALL have oReady  out  1  byte accepted on the cycle where iValid && oReady.
REQ-007 SHALL have iReqa / iReqb  in  1 each  consumer A / B requests one byte per cycle, level-sensitive.
REQ-008 SHALL have oWriteEnable  out  1, oAddress  out  ADDR_WIDTH, oDataIn  out  DATA_WIDTH  memory write port.
REQ-009 SHALL have oReadAddress  out  ADDR_WIDTH, oReadtoa / oReadtob  out  1 each  memory read port and port-select strobes.
REQ-010 SHALL have oDataValida / oDataValidb  out  1 each  memory output oDataOuta / oDataOutb valid.
REQ-011 SHALL have oCount  out  ADDR_WIDTH+1  accepted bytes held; oFull, oEmpty  out  1; oOverflow  out  1  sticky error.

Function
REQ-012 SHALL operate the memory as a circular FIFO: write pointer wr_ptr, read pointer rd_ptr, both ADDR_WIDTH bits, wrapping 1023 -> 0.
REQ-013 SHALL drive oReady = !oFull combinationally; oFull = (oCount == 1024).
REQ-014 SHALL, on acceptance at cycle N, drive oWriteEnable=1, oAddress=wr_ptr, oDataIn=iData (registered) for exactly cycle N+1; wr_ptr increments at the end of cycle N.
REQ-015 SHALL increment oCount at acceptance; decrement it at read issue; leave it unchanged when both occur in the same cycle.
REQ-016 SHALL compute read eligibility from committed entries = oCount minus a pending-write flag, so a byte accepted at N is readable at the earliest at N+2.
REQ-017 SHALL drive oEmpty = (committed entries == 0).
REQ-018 SHALL arbitrate reads with FSM states IDLE, GRANT_A, GRANT_B, re-evaluated every cycle: IDLE when empty or no request; otherwise the granted requester's state.
REQ-019 SHALL, when only one of iReqa/iReqb is high, grant that one; when both are high, grant the one opposite to the last grant (round-robin); last-grant resets to B, so A wins the first tie.
REQ-020 SHALL, in GRANT_x, drive oReadAddress=rd_ptr and oReadtox=1 (registered, one cycle per grant), then increment rd_ptr; never assert oReadtoa and oReadtob together.
REQ-021 SHALL assert oDataValidx exactly one cycle after oReadtox.
REQ-022 SHALL, for a held request, issue one read per cycle while entries remain and drop the strobe the cycle empty becomes true.
REQ-023 SHALL set oOverflow when iValid=1 while oFull=1; the byte is not written; oOverflow stays set until reset.
REQ-024 SHALL keep oCount, oFull, oEmpty consistent at pointer wrap (e.g. wr_ptr=0, rd_ptr=0, count=1024 is full).

Reset
REQ-025 SHALL, on Reset asserted at any time including mid-transfer, asynchronously clear wr_ptr, rd_ptr, oCount, pending-write flag, oOverflow, all strobes and valids, oAddress, oReadAddress, oDataIn to 0, FSM to IDLE, last-grant to B.
REQ-026 SHALL, during reset, output oEmpty=1, oFull=0, oReady=1 (combinational on cleared count); memory contents are not cleared.

Structure
REQ-027 SHALL place DATA_WIDTH, ADDR_WIDTH defaults and FSM state encodings (IDLE=0, GRANT_A=1, GRANT_B=2) in the shared package mem_pkg used by the memory block and bench.
REQ-028 SHALL implement the round-robin grant logic as sub-module rr_arbiter2; pointer/count logic stays in mem_stream_ctrl.

Verification
REQ-029 SHALL cover: write 0x11,0x22,0x33 back-to-back, iReqa held -> oWriteEnable at addr 0,1,2; oReadtoa at addr 0,1,2 from two cycles after first acceptance; oDataOuta 0x11,0x22,0x33.
REQ-030 SHALL cover: fill 1024 bytes -> oFull=1, oReady=0; 1025th iValid -> oOverflow=1, oCount stays 1024, no write strobe.
REQ-031 SHALL cover: 4 bytes loaded, iReqa and iReqb both held -> grants A,B,A,B at addresses 0..3, then oEmpty=1, no further strobes.
REQ-032 SHALL cover: wr_ptr/rd_ptr at 1022, write 4 bytes and read 4 -> addresses 1022,1023,0,1; oCount returns to 0.
REQ-033 SHALL cover: simultaneous accept and read with count 5 -> oCount stays 5.
REQ-034 SHALL cover: Reset pulsed mid-stream with count 7 -> all outputs at reset values immediately, oCount=0, next write goes to address 0.
